// File: rtl/crypto_engine_ctrl_if.sv
// Host/engine signal bundle for crypto_engine_ctrl: command channel, engine
// handshake, result FIFO head and status flags.
interface crypto_engine_ctrl_if #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2048
);
  localparam int AW = $clog2(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_rekey;
  logic [WIDTH-1:0] cmd_key;
  logic [WIDTH-1:0] cmd_data;

  logic             eng_ready;
  logic             eng_init;
  logic [WIDTH-1:0] eng_key;
  logic             eng_start;
  logic [WIDTH-1:0] eng_din;
  logic             eng_done_init;
  logic             eng_done;
  logic [WIDTH-1:0] eng_dout;
  logic             eng_dout_valid;
  logic [AW-1:0]    eng_addr;

  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_addr;
  logic             out_valid;
  logic             out_ready;

  logic             busy;
  logic             err_timeout;
  logic             err_overflow;

  modport slave (
    input  cmd_valid, cmd_rekey, cmd_key, cmd_data,
    output cmd_ready,
    input  eng_ready, eng_done_init, eng_done, eng_dout, eng_dout_valid, eng_addr,
    output eng_init, eng_key, eng_start, eng_din,
    output out_data, out_addr, out_valid,
    input  out_ready,
    output busy, err_timeout, err_overflow
  );

  modport master (
    output cmd_valid, cmd_rekey, cmd_key, cmd_data,
    input  cmd_ready,
    output eng_ready, eng_done_init, eng_done, eng_dout, eng_dout_valid, eng_addr,
    input  eng_init, eng_key, eng_start, eng_din,
    input  out_data, out_addr, out_valid,
    output out_ready,
    input  busy, err_timeout, err_overflow
  );
endinterface

// File: rtl/crypto_engine_ctrl.sv
// Host-side initiator for crypto_engine: key scheduling, block start, and a
// small result FIFO that absorbs the engine's non-stallable output stream.
module crypto_engine_ctrl #(
  parameter int WIDTH      = 128,
  parameter int DEPTH      = 2048,
  parameter int TIMEOUT    = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  crypto_engine_ctrl_if.slave  bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int PW  = FAW + 1;
  localparam int EW  = AW + WIDTH;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_INIT,
    START,
    RUN,
    ERR
  } state_t;

  state_t           state;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             eng_init_q;
  logic             eng_start_q;
  logic             key_loaded;
  logic             err_timeout_q;
  logic             err_overflow_q;
  logic [WIDTH-1:0] eng_key_q;
  logic [WIDTH-1:0] eng_din_q;
  logic [WDW-1:0]   wd_cnt;

  logic             accept;
  logic             wd_expired;

  assign accept     = bus.cmd_valid && cmd_ready_q;
  assign wd_expired = (wd_cnt == WDW'(TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      eng_init_q    <= 1'b0;
      eng_start_q   <= 1'b0;
      key_loaded    <= 1'b0;
      err_timeout_q <= 1'b0;
      eng_key_q     <= '0;
      eng_din_q     <= '0;
      wd_cnt        <= '0;
    end else begin
      eng_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            eng_key_q     <= bus.cmd_key;
            eng_din_q     <= bus.cmd_data;
            err_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            wd_cnt        <= '0;
            if (bus.cmd_rekey || !key_loaded) begin
              state      <= INIT;
              eng_init_q <= 1'b1;
            end else begin
              state <= START;
            end
          end
        end
        // done_init is honoured from the very first INIT cycle
        INIT: begin
          if (bus.eng_done_init) begin
            state      <= WAIT_INIT;
            eng_init_q <= 1'b0;
            key_loaded <= 1'b1;
            wd_cnt     <= '0;
          end else if (wd_expired) begin
            state         <= ERR;
            eng_init_q    <= 1'b0;
            err_timeout_q <= 1'b1;
            wd_cnt        <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        WAIT_INIT: begin
          state  <= START;
          wd_cnt <= '0;
        end
        START: begin
          if (bus.eng_ready) begin
            state       <= RUN;
            eng_start_q <= 1'b1;
            wd_cnt      <= '0;
          end else if (wd_expired) begin
            state         <= ERR;
            err_timeout_q <= 1'b1;
            wd_cnt        <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.eng_done) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wd_cnt      <= '0;
          end else if (wd_expired) begin
            state         <= ERR;
            err_timeout_q <= 1'b1;
            wd_cnt        <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ERR: begin
          state       <= IDLE;
          eng_init_q  <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          wd_cnt      <= '0;
        end
        default: begin
          state       <= IDLE;
          eng_init_q  <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          wd_cnt      <= '0;
        end
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FAW-1:0] == rd_ptr[FAW-1:0]) && (wr_ptr[FAW] != rd_ptr[FAW]);
  assign pop   = bus.out_ready && !empty;
  // A simultaneous pop frees the slot, so a full FIFO only drops without one
  assign drop  = bus.eng_dout_valid && full && !pop;
  assign push  = bus.eng_dout_valid && !drop;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[FAW-1:0]] <= {bus.eng_addr, bus.eng_dout};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        err_overflow_q <= 1'b1;
      end else if (accept) begin
        err_overflow_q <= 1'b0;
      end
    end
  end

  assign head = empty ? '0 : mem[rd_ptr[FAW-1:0]];

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.eng_init     = eng_init_q;
  assign bus.eng_key      = eng_key_q;
  assign bus.eng_start    = eng_start_q;
  assign bus.eng_din      = eng_din_q;
  assign bus.out_data     = head[WIDTH-1:0];
  assign bus.out_addr     = head[EW-1:WIDTH];
  assign bus.out_valid    = !empty;
  assign bus.busy         = busy_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.err_overflow = err_overflow_q;
endmodule

// File: tb/tb_crypto_engine_ctrl.sv
// Directed bench for crypto_engine_ctrl: inline checks on the control FSM and a
// queue-based scoreboard that checks every FIFO pop.
module tb_crypto_engine_ctrl;
  localparam int WIDTH      = 128;
  localparam int DEPTH      = 2048;
  localparam int AW         = 11;
  localparam int EW         = AW + WIDTH;
  localparam int TIMEOUT    = 16;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [EW-1:0] exp_q[$];

  crypto_engine_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  crypto_engine_ctrl #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] res_data(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(a);
    return {4{w}};
  endfunction

  task automatic push_result(input int a, input bit kept);
    logic [AW-1:0] ad;
    ad = AW'(a);
    bus.eng_dout_valid = 1'b1;
    bus.eng_addr       = ad;
    bus.eng_dout       = res_data(a);
    if (kept) exp_q.push_back({ad, res_data(a)});
    step();
  endtask

  task automatic issue(input bit rekey, input logic [WIDTH-1:0] key, input logic [WIDTH-1:0] data);
    chk("cmd_ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rekey = rekey;
    bus.cmd_key   = key;
    bus.cmd_data  = data;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_rekey = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!bus.eng_start && n < 20) begin
      step();
      n++;
    end
    chk("start_seen", bus.eng_start, 1);
  endtask

  task automatic finish_run();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    chk("busy_after_done", bus.busy, 0);
    chk("ready_after_done", bus.cmd_ready, 1);
  endtask

  // Scoreboard monitor: inputs change just after posedge, so negedge sees the
  // values the DUT will act on at the next edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got addr %0h data %0h, required no entry", bus.out_addr, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", {bus.out_addr, bus.out_data}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.cmd_valid      = 1'b0;
    bus.cmd_rekey      = 1'b0;
    bus.cmd_key        = '0;
    bus.cmd_data       = '0;
    bus.eng_ready      = 1'b0;
    bus.eng_done_init  = 1'b0;
    bus.eng_done       = 1'b0;
    bus.eng_dout       = '0;
    bus.eng_dout_valid = 1'b0;
    bus.eng_addr       = '0;
    bus.out_ready      = 1'b0;
    #1 rst = 1'b1;
    step();
    step();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_eng_init", bus.eng_init, 0);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_eng_key", bus.eng_key, 0);
    chk("rst_eng_din", bus.eng_din, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_err_timeout", bus.err_timeout, 0);
    chk("rst_err_overflow", bus.err_overflow, 0);
    rst = 1'b0;
    step();

    // Rekey command; engine answers done_init in the third init cycle
    bus.eng_ready = 1'b1;
    issue(1'b1, '0, '1);
    chk("t1_init_high", bus.eng_init, 1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_cmd_ready_low", bus.cmd_ready, 0);
    n = 0;
    for (int i = 0; i < 20 && bus.eng_init; i++) begin
      n++;
      bus.eng_done_init = (n == 3);
      step();
    end
    bus.eng_done_init = 1'b0;
    chk("t1_init_cycles", 32'(n), 3);
    chk("t1_wait_init_start", bus.eng_start, 0);
    chk("t1_wait_init_busy", bus.busy, 1);
    wait_start(n);
    chk("t1_start_latency", 32'(n), 2);
    chk("t1_eng_din", bus.eng_din, {WIDTH{1'b1}});
    chk("t1_eng_key", bus.eng_key, 0);
    chk("t1_init_low_at_start", bus.eng_init, 0);
    step();
    chk("t1_start_one_cycle", bus.eng_start, 0);
    chk("t1_busy_in_run", bus.busy, 1);
    finish_run();

    // No-rekey command goes straight to START
    issue(1'b0, {4{32'hA5A5_5A5A}}, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("t2_no_init", bus.eng_init, 0);
    chk("t2_no_start_yet", bus.eng_start, 0);
    chk("t2_eng_key", bus.eng_key, {4{32'hA5A5_5A5A}});
    step();
    chk("t2_start", bus.eng_start, 1);
    chk("t2_no_init_2", bus.eng_init, 0);
    chk("t2_eng_din", bus.eng_din, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    step();
    chk("t2_start_one_cycle", bus.eng_start, 0);
    finish_run();

    // Six results into a four-entry FIFO with no consumer
    bus.out_ready = 1'b0;
    for (int a = 0; a < 6; a++) push_result(a, a < 4);
    bus.eng_dout_valid = 1'b0;
    chk("t3_err_overflow", bus.err_overflow, 1);
    chk("t3_out_valid", bus.out_valid, 1);
    chk("t3_head_addr", bus.out_addr, 0);
    step();
    chk("t3_head_stable", bus.out_addr, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t3_drained", bus.out_valid, 0);
    chk("t3_sb_drained", 32'(exp_q.size()), 0);
    step();
    step();
    chk("t3_empty_pop_noop", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    push_result(30, 1'b1);
    bus.eng_dout_valid = 1'b0;
    chk("t3_latency_one", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t3_single_popped", bus.out_valid, 0);

    // Next accepted command clears the sticky overflow flag
    issue(1'b0, '0, 128'h1111);
    chk("t3_overflow_cleared", bus.err_overflow, 0);
    wait_start(n);
    step();
    finish_run();

    // Full FIFO with simultaneous push and pop
    for (int a = 10; a < 14; a++) push_result(a, 1'b1);
    bus.out_ready = 1'b1;
    for (int a = 14; a < 20; a++) push_result(a, 1'b1);
    bus.eng_dout_valid = 1'b0;
    chk("t4_no_overflow", bus.err_overflow, 0);
    chk("t4_still_full", bus.out_valid, 1);
    for (int i = 0; i < 4; i++) step();
    bus.out_ready = 1'b0;
    chk("t4_drained", bus.out_valid, 0);
    chk("t4_sb_drained", 32'(exp_q.size()), 0);

    // done_init never arrives: watchdog expires after TIMEOUT init cycles
    issue(1'b1, {4{32'h0BAD_F00D}}, 128'h2222);
    n = 0;
    while (bus.eng_init && n < 40) begin
      n++;
      step();
    end
    chk("t5_init_cycles", 32'(n), TIMEOUT);
    chk("t5_err_timeout", bus.err_timeout, 1);
    chk("t5_err_busy", bus.busy, 1);
    chk("t5_err_no_start", bus.eng_start, 0);
    chk("t5_err_cmd_ready", bus.cmd_ready, 0);
    step();
    chk("t5_idle_busy", bus.busy, 0);
    chk("t5_idle_ready", bus.cmd_ready, 1);
    chk("t5_sticky", bus.err_timeout, 1);
    issue(1'b0, '0, 128'h3333);
    chk("t5_timeout_cleared", bus.err_timeout, 0);
    chk("t5_no_init", bus.eng_init, 0);
    wait_start(n);
    step();
    finish_run();

    // Reset while RUN with two results buffered
    issue(1'b0, '0, 128'h4444);
    push_result(20, 1'b0);
    chk("t6_start", bus.eng_start, 1);
    push_result(21, 1'b0);
    bus.eng_dout_valid = 1'b0;
    chk("t6_busy", bus.busy, 1);
    chk("t6_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_eng_start", bus.eng_start, 0);
    chk("t6_rst_eng_init", bus.eng_init, 0);
    chk("t6_rst_cmd_ready", bus.cmd_ready, 1);
    chk("t6_rst_eng_din", bus.eng_din, 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_post_out_valid", bus.out_valid, 0);
    chk("sb_final_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
